// File: rtl/fetch_stage.sv
// Instruction fetch stage: fetch PC, small {pc_plus4, instr} buffer and a
// RUN/WAIT/DROP request FSM that tolerates multi-cycle memory acks and redirects.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic        stall,
    output logic        if_valid,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc_plus4
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    localparam logic [1:0] RUN  = 2'd0;
    localparam logic [1:0] WAIT = 2'd1;
    localparam logic [1:0] DROP = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [31:0]      pc_q, pc_d;
    logic [31:0]      raddr_q, raddr_d;
    logic             started_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [PTR_W-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [31:0]      instr_q [DEPTH];
    logic [31:0]      pc4_q   [DEPTH];

    logic        accept, push, pop;
    logic [31:0] fetch_pc4;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Once a request is outstanding it cannot be withdrawn, so WAIT/DROP
    // keep requesting the latched address regardless of redirect.
    always_comb begin
        imem_addr = (state_q == RUN) ? pc_q : raddr_q;
        imem_req  = started_q &&
                    ((state_q != RUN) || ((cnt_q < CNT_W'(DEPTH)) && !redirect));
        accept    = imem_req && imem_ack;
        push      = accept && (state_q != DROP) && !redirect;
        pop       = (cnt_q != '0) && !stall;
        fetch_pc4 = imem_addr + 32'd4;
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        raddr_d = raddr_q;
        cnt_d   = cnt_q;
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        if (redirect) begin
            cnt_d   = '0;
            wptr_d  = '0;
            rptr_d  = '0;
            pc_d    = {redirect_pc[31:2], 2'b00};
            state_d = ((state_q != RUN) && !imem_ack) ? DROP : RUN;
        end else begin
            case (state_q)
                RUN: begin
                    if (accept) begin
                        pc_d = fetch_pc4;
                    end else if (imem_req) begin
                        state_d = WAIT;
                        raddr_d = pc_q;
                    end
                end
                WAIT: begin
                    if (imem_ack) begin
                        pc_d    = fetch_pc4;
                        state_d = RUN;
                    end
                end
                DROP: begin
                    if (imem_ack) state_d = RUN;
                end
                default: state_d = RUN;
            endcase
            if (push) wptr_d = ptr_inc(wptr_q);
            if (pop)  rptr_d = ptr_inc(rptr_q);
            if (push && !pop)      cnt_d = cnt_q + 1'b1;
            else if (pop && !push) cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= RUN;
            pc_q      <= RESET_PC;
            raddr_q   <= RESET_PC;
            started_q <= 1'b0;
            cnt_q     <= '0;
            wptr_q    <= '0;
            rptr_q    <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            raddr_q   <= raddr_d;
            started_q <= 1'b1;
            cnt_q     <= cnt_d;
            wptr_q    <= wptr_d;
            rptr_q    <= rptr_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                instr_q[i] <= '0;
                pc4_q[i]   <= '0;
            end
        end else if (push) begin
            instr_q[wptr_q] <= imem_rdata;
            pc4_q[wptr_q]   <= fetch_pc4;
        end
    end

    assign if_valid    = (cnt_q != '0);
    assign if_instr    = instr_q[rptr_q];
    assign if_pc_plus4 = pc4_q[rptr_q];
endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: a queue-based model of the fetch stream
// checked every cycle, plus literal expectations on key cycles.
module tb_fetch_stage;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, imem_ack, redirect, stall;
    logic [31:0] imem_rdata, redirect_pc;
    logic        imem_req, if_valid;
    logic [31:0] imem_addr, if_instr, if_pc_plus4;
    logic        req2, valid2;
    logic [31:0] addr2, instr2, pc42;

    fetch_stage dut (
        .clk(clk), .rst_n(rst_n), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata), .redirect(redirect),
        .redirect_pc(redirect_pc), .stall(stall), .if_valid(if_valid),
        .if_instr(if_instr), .if_pc_plus4(if_pc_plus4)
    );

    fetch_stage #(.RESET_PC(32'hFFFF_FFF8)) dut2 (
        .clk(clk), .rst_n(rst_n), .imem_req(req2), .imem_addr(addr2),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata), .redirect(redirect),
        .redirect_pc(redirect_pc), .stall(stall), .if_valid(valid2),
        .if_instr(instr2), .if_pc_plus4(pc42)
    );

    int tests = 0;
    int fails = 0;

    // Model: queue of buffered pc_plus4 values; instruction is derived from address.
    logic [31:0] mq[$];
    logic [31:0] m_pc, m_oaddr;
    bit          m_out, m_drop, m_started;

    logic        s_req, s_valid;
    logic [31:0] s_addr, s_pc4, s_addr2;

    function automatic logic [31:0] mem_f(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_pc = 32'h0; m_oaddr = 32'h0;
        m_out = 0; m_drop = 0; m_started = 0;
    endtask

    // Entered and left on a falling edge.
    task automatic rst();
        rst_n = 1'b0; imem_ack = 1'b0; stall = 1'b0; redirect = 1'b0;
        redirect_pc = 32'h0; imem_rdata = 32'h0;
        #2;
        chk("rst_imem_req", imem_req, 0);
        chk("rst_if_valid", if_valid, 0);
        chk("rst_if_instr", if_instr, 0);
        chk("rst_if_pc_plus4", if_pc_plus4, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic cyc(input bit ack, input bit st, input bit rd, input logic [31:0] rpc);
        bit e_req, pop, acc;
        logic [31:0] e_addr;
        imem_ack = ack; stall = st; redirect = rd; redirect_pc = rpc;
        #1 imem_rdata = ack ? mem_f(imem_addr) : 32'hDEAD_BEEF;
        #1;
        e_req  = m_started && (m_out || ((mq.size() < 2) && !rd));
        e_addr = m_out ? m_oaddr : m_pc;
        chk("imem_req", imem_req, e_req);
        if (e_req) chk("imem_addr", imem_addr, e_addr);
        chk("if_valid", if_valid, mq.size() != 0);
        if (mq.size() != 0) begin
            chk("if_pc_plus4", if_pc_plus4, mq[0]);
            chk("if_instr", if_instr, mem_f(mq[0] - 32'd4));
        end
        s_req = imem_req; s_addr = imem_addr; s_valid = if_valid;
        s_pc4 = if_pc_plus4; s_addr2 = addr2;
        @(posedge clk);
        pop = (mq.size() != 0) && !st;
        acc = e_req && ack;
        if (rd) begin
            mq.delete();
            m_pc = {rpc[31:2], 2'b00};
            if (m_out && !acc) m_drop = 1;
            else begin m_out = 0; m_drop = 0; end
        end else begin
            if (pop) void'(mq.pop_front());
            if (acc) begin
                if (!m_drop) begin
                    mq.push_back(e_addr + 32'd4);
                    m_pc = e_addr + 32'd4;
                end
                m_out = 0; m_drop = 0;
            end else if (e_req) begin
                m_out = 1; m_oaddr = e_addr;
            end
        end
        m_started = 1;
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0; imem_ack = 1'b0; stall = 1'b0; redirect = 1'b0;
        redirect_pc = 32'h0; imem_rdata = 32'h0;
        model_reset();
        @(negedge clk);

        // Streaming with ack tied high, plus the wrapping instance.
        rst();
        cyc(1, 0, 0, 0); chk("lit_first_edge_no_req", s_req, 0);
        cyc(1, 0, 0, 0); chk("lit_addr0", s_addr, 32'h0);
                         chk("lit_wrap_addr0", s_addr2, 32'hFFFF_FFF8);
        cyc(1, 0, 0, 0); chk("lit_addr4", s_addr, 32'h4);
                         chk("lit_pc4_4", s_pc4, 32'h4);
                         chk("lit_wrap_addr1", s_addr2, 32'hFFFF_FFFC);
        cyc(1, 0, 0, 0); chk("lit_addr8", s_addr, 32'h8);
                         chk("lit_pc4_8", s_pc4, 32'h8);
                         chk("lit_wrap_addr2", s_addr2, 32'h0);
        repeat (3) cyc(1, 0, 0, 0);

        // Ack delayed three cycles on address 0x8.
        rst();
        repeat (3) cyc(1, 0, 0, 0);
        repeat (3) begin
            cyc(0, 0, 0, 0); chk("lit_hold_addr8", s_addr, 32'h8);
        end
        repeat (4) cyc(1, 0, 0, 0);

        // Stall with ack high: two entries buffered, request drops.
        rst();
        repeat (5) cyc(1, 1, 0, 0);
        chk("lit_stall_req_low", s_req, 0);
        chk("lit_stall_head", s_pc4, 32'h4);
        repeat (4) cyc(0, 0, 0, 0);

        // Redirect during WAIT on 0x10, memory acks two cycles later.
        rst();
        repeat (5) cyc(1, 0, 0, 0);
        cyc(0, 0, 0, 0);
        cyc(0, 0, 1, 32'h0000_0043); chk("lit_drop_keeps_addr", s_addr, 32'h10);
        cyc(0, 0, 0, 0);
        cyc(1, 0, 0, 0);
        cyc(1, 0, 0, 0); chk("lit_refetch_40", s_addr, 32'h40);
        cyc(1, 0, 0, 0); chk("lit_pc4_44", s_pc4, 32'h44);
        repeat (2) cyc(1, 0, 0, 0);

        // Redirect with a full buffer, ack and pop all in one cycle.
        rst();
        repeat (4) cyc(1, 1, 0, 0);
        cyc(1, 0, 1, 32'h0000_0080);
        cyc(1, 0, 0, 0); chk("lit_flush_valid", s_valid, 0);
                         chk("lit_flush_addr", s_addr, 32'h80);
        repeat (2) cyc(1, 0, 0, 0);

        // Reset while waiting; a late ack right after reset is ignored.
        rst();
        repeat (2) cyc(1, 0, 0, 0);
        cyc(0, 0, 0, 0);
        rst();
        repeat (4) cyc(1, 0, 0, 0);

        // Double redirect in DROP, redirect+ack in WAIT, PC wrap via redirect.
        rst();
        repeat (2) cyc(1, 0, 0, 0);
        cyc(0, 0, 0, 0);
        cyc(0, 0, 1, 32'h100);
        cyc(0, 0, 1, 32'h200);
        cyc(1, 0, 0, 0);
        cyc(1, 0, 0, 0); chk("lit_newest_redirect", s_addr, 32'h200);
        cyc(0, 1, 0, 0);
        cyc(1, 1, 1, 32'h300);
        cyc(1, 0, 0, 0); chk("lit_wait_ack_redirect", s_addr, 32'h300);
        cyc(1, 0, 1, 32'hFFFF_FFFC);
        repeat (3) cyc(1, 0, 0, 0);
        cyc(1, 1, 0, 0); cyc(0, 0, 0, 0); cyc(1, 1, 0, 0); cyc(1, 0, 0, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, address fetched first after reset.
REQ-002 Parameter DEPTH, default 2, instruction-buffer entries (fixed at 2 for this release).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 imem_req  output  1  fetch request valid to instruction memory.
REQ-006 imem_addr  output  32  word-aligned fetch address; held stable while imem_req=1 and imem_ack=0.
REQ-007 imem_ack  input  1  memory accepted the request and returns imem_rdata this cycle.
REQ-008 imem_rdata  input  32  instruction word, valid only when imem_ack=1.
REQ-009 redirect  input  1  branch taken (pcSrc from EX/MEM); flush and refetch.
REQ-010 redirect_pc  input  32  branch target address.
REQ-011 stall  input  1  IF/ID holds; do not pop buffer.
REQ-012 if_valid  output  1  if_instr/if_pc_plus4 hold a valid instruction for IF/ID.
REQ-013 if_instr  output  32  instruction at buffer head.
REQ-014 if_pc_plus4  output  32  fetch address of head instruction plus 4.

Function
REQ-015 The block SHALL hold a fetch PC register, a DEPTH-entry FIFO of {pc_plus4, instr}, and an FSM with states RUN, WAIT, DROP.
REQ-016 RUN: imem_req SHALL assert when (fifo_count < DEPTH) and redirect=0; imem_addr = fetch PC.
REQ-017 RUN with imem_req=1, imem_ack=1: push {PC+4, imem_rdata}, PC <= PC+4, stay RUN (single-cycle memory = 1 instruction/cycle).
REQ-018 RUN with imem_req=1, imem_ack=0: go WAIT; imem_req and imem_addr SHALL stay asserted/stable.
REQ-019 WAIT with imem_ack=1: push, PC <= PC+4, go RUN.
REQ-020 Pop SHALL occur when if_valid=1 and stall=0; push and pop in the same cycle SHALL leave fifo_count unchanged.
REQ-021 A push SHALL never be issued into a full FIFO; a request is only started when a slot is reserved for it.
REQ-022 if_valid = (fifo_count != 0); if_instr/if_pc_plus4 SHALL be the head entry, registered, no combinational path from imem_rdata.
REQ-023 redirect=1 (any state) SHALL: clear FIFO (if_valid=0 next cycle), PC <= redirect_pc, discard any imem_rdata acked that cycle.
REQ-024 redirect while in WAIT with no ack that cycle SHALL go DROP; imem_req remains 1 with the old address until acked (request cannot be withdrawn).
REQ-025 DROP with imem_ack=1: discard data, go RUN; fetch from redirect_pc starts next cycle.
REQ-026 redirect in DROP SHALL update PC to the newest redirect_pc and stay DROP.
REQ-027 redirect has priority over stall, push and pop in the same cycle.
REQ-028 PC arithmetic SHALL be 32-bit modulo 2^32 (32'hFFFF_FFFC + 4 = 0); redirect_pc[1:0] SHALL be forced to 00.
REQ-029 FIFO pointers SHALL wrap modulo DEPTH; fifo_count range 0..DEPTH.

Reset
REQ-030 rst_n=0 SHALL asynchronously set: PC=RESET_PC, state=RUN, fifo_count=0, pointers=0, if_valid=0, imem_req=0, if_instr=0, if_pc_plus4=0.
REQ-031 imem_req SHALL remain 0 for the first clk edge after rst_n deasserts; first request issued the cycle after.
REQ-032 rst_n asserted in WAIT/DROP SHALL abandon the outstanding request; a late imem_ack after reset SHALL be ignored unless a new request is active.

Verification
REQ-033 Reset release, imem_ack tied 1, stall=0 -> addresses 0,4,8,... one per cycle; if_valid from cycle 2; if_pc_plus4=4,8,12 in order.
REQ-034 imem_ack delayed 3 cycles on addr 0x8 -> imem_addr held 0x8 all 3 cycles, single push, no duplicate or lost instruction.
REQ-035 stall=1 for 5 cycles with ack=1 -> exactly 2 instructions buffered, imem_req drops, head unchanged; stall release -> drains in order 0,4.
REQ-036 redirect to 0x40 during WAIT on 0x10, ack 2 cycles later -> 0x10 data discarded, next request 0x40, first if_pc_plus4=0x44.
REQ-037 redirect + ack + pop in same cycle with FIFO full -> FIFO empty next cycle, PC=redirect_pc.
REQ-038 RESET_PC=32'hFFFF_FFF8, ack=1 -> addresses FFFF_FFF8, FFFF_FFFC, 0000_0000 (wrap).
